// File: rtl/imem_loader_if.sv
// Host-side byte stream/control and instruction RAM write port of the boot loader.
interface imem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output start, rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );

    modport slave (
        input  start, rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, cpu_hold, busy, done, error
    );
endinterface

// File: rtl/imem_loader.sv
// UART boot loader: 16-bit big-endian word count header, then big-endian 32-bit words
// written to consecutive instruction RAM word addresses while the CPU is held in reset.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic         clk,
    input  logic         reset,
    imem_loader_if.slave bus
);
    localparam int unsigned   TW        = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned   CAPACITY  = 1 << ADDR_WIDTH;
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE, S_ERROR
    } state_t;

    state_t                state, state_nxt;
    logic [15:0]           len, len_nxt, len_in;
    logic [23:0]           shreg, shreg_nxt;
    logic [1:0]            byte_idx, byte_nxt;
    logic [ADDR_WIDTH:0]   word_idx, word_nxt;
    logic [TW-1:0]         tcnt, tcnt_nxt;
    logic                  timed_out;
    logic [31:0]           addr_nxt, wdata_nxt;
    logic                  mem_we_q, cpu_hold_q, busy_q, done_q, error_q;
    logic [31:0]           mem_addr_q, mem_wdata_q;

    always_comb begin
        state_nxt = state;
        len_nxt   = len;
        len_in    = {len[15:8], bus.rx_data};
        shreg_nxt = shreg;
        byte_nxt  = byte_idx;
        word_nxt  = word_idx;
        tcnt_nxt  = tcnt;
        timed_out = 1'b0;
        addr_nxt  = mem_addr_q;
        wdata_nxt = mem_wdata_q;

        // Timeout fires on the idle cycle that brings the counter to TIMEOUT_CYCLES-1.
        if (state inside {S_LEN_HI, S_LEN_LO, S_DATA}) begin
            if (bus.rx_valid) begin
                tcnt_nxt = '0;
            end else begin
                tcnt_nxt  = tcnt + TW'(1);
                timed_out = (tcnt == TCNT_LAST);
            end
        end

        case (state)
            S_IDLE, S_ERROR: begin
                if (bus.start) begin
                    state_nxt = S_LEN_HI;
                    tcnt_nxt  = '0;
                end
            end
            S_DONE: begin
                state_nxt = bus.start ? S_LEN_HI : S_IDLE;
                tcnt_nxt  = '0;
            end
            S_LEN_HI: begin
                if (bus.rx_valid) begin
                    len_nxt   = {bus.rx_data, len[7:0]};
                    state_nxt = S_LEN_LO;
                end else if (timed_out) begin
                    state_nxt = S_ERROR;
                end
            end
            S_LEN_LO: begin
                if (bus.rx_valid) begin
                    len_nxt = len_in;
                    if (len_in == '0) begin
                        state_nxt = S_DONE;
                    end else if (32'(len_in) > CAPACITY) begin
                        state_nxt = S_ERROR;
                    end else begin
                        state_nxt = S_DATA;
                        word_nxt  = '0;
                        byte_nxt  = '0;
                    end
                end else if (timed_out) begin
                    state_nxt = S_ERROR;
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    shreg_nxt = {shreg[15:0], bus.rx_data};
                    byte_nxt  = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) begin
                        state_nxt = S_WRITE;
                        wdata_nxt = {shreg, bus.rx_data};
                        addr_nxt  = 32'({word_idx[ADDR_WIDTH-1:0], 2'b00});
                    end
                end else if (timed_out) begin
                    state_nxt = S_ERROR;
                end
            end
            S_WRITE: begin
                if (bus.rx_valid) begin
                    state_nxt = S_ERROR;
                end else begin
                    word_nxt  = word_idx + (ADDR_WIDTH + 1)'(1);
                    byte_nxt  = '0;
                    state_nxt = (32'(word_idx) + 32'd1 == 32'(len)) ? S_DONE : S_DATA;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Status outputs are registered decodes of the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            len         <= '0;
            shreg       <= '0;
            byte_idx    <= '0;
            word_idx    <= '0;
            tcnt        <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            len         <= len_nxt;
            shreg       <= shreg_nxt;
            byte_idx    <= byte_nxt;
            word_idx    <= word_nxt;
            tcnt        <= tcnt_nxt;
            mem_we_q    <= (state_nxt == S_WRITE);
            mem_addr_q  <= addr_nxt;
            mem_wdata_q <= wdata_nxt;
            cpu_hold_q  <= (state_nxt != S_IDLE);
            busy_q      <= (state_nxt inside {S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_DONE});
            done_q      <= (state_nxt == S_DONE);
            error_q     <= (state_nxt == S_ERROR);
        end
    end

    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.cpu_hold  = cpu_hold_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: per-cycle comparison against a byte-counting reference model,
// plus directed loads with literal expected RAM writes.
module tb_imem_loader;
    localparam int unsigned AW = 8;
    localparam int unsigned TO = 50;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    imem_loader_if bus();

    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [68:0] outs();
        return {bus.mem_we, bus.mem_addr, bus.mem_wdata,
                bus.cpu_hold, bus.busy, bus.done, bus.error};
    endfunction

    // Reference model: tracks bytes received, header length and words written.
    bit          m_active  = 1'b0;
    bit          m_write   = 1'b0;
    bit          m_done    = 1'b0;
    bit          m_err     = 1'b0;
    int          m_nb      = 0;
    int          m_written = 0;
    int          m_idle    = 0;
    logic [15:0] m_len     = '0;
    logic [31:0] m_word    = '0;
    logic [31:0] e_addr    = '0;
    logic [31:0] e_wdata   = '0;

    function automatic logic [68:0] expected();
        return {m_write, e_addr, e_wdata,
                m_active | m_done | m_err, m_active | m_done, m_done, m_err};
    endfunction

    task automatic model_step(input bit st, input bit rv, input logic [7:0] rd);
        bit was_write;
        was_write = m_write;
        m_write   = 1'b0;
        m_done    = 1'b0;
        if (was_write) begin
            if (rv) begin
                m_active = 1'b0;
                m_err    = 1'b1;
            end else begin
                m_written++;
                if (m_written == int'(m_len)) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end
            end
        end else if (m_active) begin
            if (rv) begin
                m_idle = 0;
                m_nb++;
                if (m_nb == 1) begin
                    m_len[15:8] = rd;
                end else if (m_nb == 2) begin
                    m_len[7:0] = rd;
                    if (m_len == 16'd0) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end else if (int'(m_len) > (1 << AW)) begin
                        m_active = 1'b0;
                        m_err    = 1'b1;
                    end
                end else begin
                    m_word = {m_word[23:0], rd};
                    if ((m_nb - 2) % 4 == 0) begin
                        m_write = 1'b1;
                        e_addr  = 32'(m_written * 4);
                        e_wdata = m_word;
                    end
                end
            end else begin
                m_idle++;
                if (m_idle == int'(TO) - 1) begin
                    m_active = 1'b0;
                    m_err    = 1'b1;
                end
            end
        end else if (st) begin
            m_active  = 1'b1;
            m_err     = 1'b0;
            m_nb      = 0;
            m_written = 0;
            m_idle    = 0;
        end
    endtask

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_active = 1'b0; m_write = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_nb = 0; m_written = 0; m_idle = 0;
            m_len = '0; m_word = '0; e_addr = '0; e_wdata = '0;
        end else begin
            model_step(bus.start, bus.rx_valid, bus.rx_data);
        end
    end

    // Per-cycle compare plus write/done logging for the directed checks.
    logic [63:0] wlog[$];
    int          done_cnt = 0;
    logic [31:0] max_addr = '0;

    initial forever begin
        @(negedge clk);
        chk("cycle", outs(), expected());
        if (bus.mem_we) begin
            wlog.push_back({bus.mem_addr, bus.mem_wdata});
            if (bus.mem_addr > max_addr) max_addr = bus.mem_addr;
        end
        if (bus.done) done_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
    endtask

    logic [31:0] norm_words[5] = '{32'h3c084000, 32'h2508000c, 32'h8d040004,
                                   32'had040000, 32'h08000004};
    int d0;
    int n;

    initial begin
        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = '0;
        #1 reset = 1'b1;
        idle(3);
        #1 chk("reset_outputs", outs(), '0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // Normal 5-word load
        wlog.delete(); d0 = done_cnt;
        pulse_start();
        chk("start_hold_busy", {bus.cpu_hold, bus.busy}, 2'b11);
        send_byte(8'h00); send_byte(8'h05);
        foreach (norm_words[i]) send_word(norm_words[i]);
        idle(4);
        chk("norm_nwrites", wlog.size(), 5);
        for (int i = 0; i < 5 && i < wlog.size(); i++)
            chk($sformatf("norm_write%0d", i), wlog[i], {32'(i * 4), norm_words[i]});
        chk("norm_done", done_cnt - d0, 1);
        chk("norm_released", {bus.cpu_hold, bus.busy}, 2'b00);

        // Empty header
        wlog.delete(); d0 = done_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h00);
        idle(2);
        chk("empty_done", done_cnt - d0, 1);
        chk("empty_nwrites", wlog.size(), 0);

        // Bytes in IDLE ignored; start during DATA ignored
        wlog.delete(); d0 = done_cnt;
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h12);
        chk("idle_ignores_rx", {bus.busy, bus.cpu_hold}, 2'b00);
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'hde); send_byte(8'had);
        pulse_start();
        send_byte(8'hbe); send_byte(8'hef);
        pulse_start();
        send_word(32'h01234567);
        idle(3);
        chk("ign_nwrites", wlog.size(), 2);
        if (wlog.size() == 2) begin
            chk("ign_write0", wlog[0], {32'h0, 32'hdeadbeef});
            chk("ign_write1", wlog[1], {32'h4, 32'h01234567});
        end
        chk("ign_done", done_cnt - d0, 1);

        // Oversize header
        wlog.delete();
        pulse_start();
        send_byte(8'h01); send_byte(8'h01);
        idle(2);
        chk("oversize_err_hold_busy", {bus.error, bus.cpu_hold, bus.busy}, 3'b110);
        chk("oversize_nwrites", wlog.size(), 0);

        // rx_valid during WRITE
        wlog.delete();
        pulse_start();
        chk("start_clears_error", bus.error, 1'b0);
        send_byte(8'h00); send_byte(8'h01);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        bus.rx_data = 8'h44; bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_data = 8'h55;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        idle(2);
        chk("wr_overrun_error", bus.error, 1'b1);
        chk("wr_overrun_nwrites", wlog.size(), 1);

        // Timeout after 6 bytes of a 2-word frame
        wlog.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        bus.rx_data = 8'h06; bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        n = 0;
        while (!bus.error && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_within_50", {bus.error, 1'(n <= 50)}, 2'b11);
        chk("timeout_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("timeout_write0", wlog[0], {32'h0, 32'h01020304});

        wlog.delete(); d0 = done_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h11223344);
        idle(3);
        chk("recover_flags", {bus.error, bus.cpu_hold}, 2'b00);
        chk("recover_done", done_cnt - d0, 1);
        if (wlog.size() == 1) chk("recover_write", wlog[0], {32'h0, 32'h11223344});
        else chk("recover_nwrites", wlog.size(), 1);

        // Full capacity
        wlog.delete(); d0 = done_cnt; max_addr = '0;
        pulse_start();
        send_byte(8'h01); send_byte(8'h00);
        for (int i = 0; i < 256; i++) send_word(32'(i));
        idle(4);
        chk("full_nwrites", wlog.size(), 256);
        if (wlog.size() == 256) begin
            chk("full_first", wlog[0], {32'h0, 32'h0});
            chk("full_last", wlog[255], {32'h3fc, 32'hff});
        end
        chk("full_max_addr", max_addr, 32'h3fc);
        chk("full_done", done_cnt - d0, 1);

        // Reset mid-load, then a clean load
        wlog.delete(); d0 = done_cnt;
        pulse_start();
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'hcafef00d);
        send_byte(8'h99); send_byte(8'h88);
        #2 reset = 1'b1;
        #1 chk("midload_reset_outputs", outs(), '0);
        idle(2);
        reset = 1'b0;
        idle(1);
        wlog.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'haabbccdd);
        idle(3);
        chk("post_reset_nwrites", wlog.size(), 1);
        if (wlog.size() == 1) chk("post_reset_write0", wlog[0], {32'h0, 32'haabbccdd});
        chk("post_reset_done", done_cnt - d0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
